// File: rtl/comp_arbiter.sv
// Round-robin arbiter sharing one registered N-bit magnitude comparator among R requesters.
// Define COMP_ARB_SIGNED_EN to compare operands as two's-complement; unsigned by default.
module comp_arbiter #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] a_in,
    input  logic [R*N-1:0] b_in,
    output logic [R-1:0]   gnt,
    output logic           busy,
    output logic           done,
    output logic           agb,
    output logic           aeb,
    output logic           alb
);

    localparam int IW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_t;

    state_t         state_q;
    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  gidx_q;
    logic [N-1:0]   opa_q;
    logic [N-1:0]   opb_q;
    logic [R-1:0]   gnt_q;
    logic           busy_q;
    logic           done_q;
    logic           agb_q;
    logic           aeb_q;
    logic           alb_q;

    logic [N-1:0]   a_arr [R];
    logic [N-1:0]   b_arr [R];
    logic [IW-1:0]  cand  [R];
    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic [R-1:0]   pick_onehot;
    logic           cmp_gt;
    logic           cmp_eq;

    // cand[gi] is the requester visited at position gi of the search starting after ptr.
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_slice
            assign a_arr[gi] = a_in[gi*N +: N];
            assign b_arr[gi] = b_in[gi*N +: N];
            assign cand[gi]  = IW'((32'(ptr_q) + 32'(gi) + 32'd1) % 32'(R));
        end
    endgenerate

    // Scanning from the far end leaves the nearest requesting candidate as the winner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = R - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[k];
            end
        end
    end

    assign pick_onehot = {{(R-1){1'b0}}, 1'b1} << pick_idx;

`ifdef COMP_ARB_SIGNED_EN
    assign cmp_gt = $signed(opa_q) > $signed(opb_q);
`else
    assign cmp_gt = opa_q > opb_q;
`endif
    assign cmp_eq = (opa_q == opb_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= IW'(R - 1);
            gidx_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            agb_q   <= 1'b0;
            aeb_q   <= 1'b0;
            alb_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (pick_found) begin
                        state_q <= S_CMP;
                        gnt_q   <= pick_onehot;
                        gidx_q  <= pick_idx;
                        opa_q   <= a_arr[pick_idx];
                        opb_q   <= b_arr[pick_idx];
                        busy_q  <= 1'b1;
                    end else begin
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                S_CMP: begin
                    agb_q   <= cmp_gt;
                    aeb_q   <= cmp_eq;
                    alb_q   <= !cmp_gt && !cmp_eq;
                    done_q  <= 1'b1;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    done_q  <= 1'b0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= gidx_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign done = done_q;
    assign agb  = agb_q;
    assign aeb  = aeb_q;
    assign alb  = alb_q;

endmodule

// File: tb/tb_comp_arbiter.sv
// Self-checking bench for comp_arbiter: directed scenarios plus random traffic vs. a cycle-level reference.
module tb_comp_arbiter;

    localparam int N = 8;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [R-1:0]   req = '0;
    logic [R*N-1:0] a_in = '0;
    logic [R*N-1:0] b_in = '0;
    logic [R-1:0]   gnt;
    logic           busy;
    logic           done;
    logic           agb;
    logic           aeb;
    logic           alb;

    comp_arbiter #(.N(N), .R(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .a_in  (a_in),
        .b_in  (b_in),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .agb   (agb),
        .aeb   (aeb),
        .alb   (alb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_owner[$];
    int done_cyc[$];

    // Reference: phase 0 = waiting, 1 = operands held, 2 = result being reported.
    int           m_phase;
    int           m_owner;
    int           m_ptr;
    logic [N-1:0] m_opa;
    logic [N-1:0] m_opb;
    logic [2:0]   m_flags;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [2:0] ref_cmp(input logic [N-1:0] a, input logic [N-1:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
`ifdef COMP_ARB_SIGNED_EN
        if (a[N-1]) ia = ia - (1 << N);
        if (b[N-1]) ib = ib - (1 << N);
`endif
        if (ia > ib)  return 3'b100;
        if (ia == ib) return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_owner = -1;
        m_ptr   = R - 1;
        m_opa   = '0;
        m_opb   = '0;
        m_flags = 3'b000;
    endtask

    task automatic model_edge();
        case (m_phase)
            0: begin
                m_owner = -1;
                for (int k = 1; k <= R; k++) begin
                    int j;
                    j = (m_ptr + k) % R;
                    if (m_owner < 0 && req[j]) m_owner = j;
                end
                if (m_owner >= 0) begin
                    m_opa   = a_in[m_owner*N +: N];
                    m_opb   = b_in[m_owner*N +: N];
                    m_phase = 1;
                end
            end
            1: begin
                m_flags = ref_cmp(m_opa, m_opb);
                m_phase = 2;
            end
            default: begin
                m_ptr   = m_owner;
                m_owner = -1;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic step();
        logic [R-1:0] exp_gnt;
        int           gi;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        cyc++;
        exp_gnt = '0;
        if (m_phase != 0) exp_gnt[m_owner] = 1'b1;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("done", 32'(done), 32'(m_phase == 2));
        check("flags", 32'({agb, aeb, alb}), 32'(m_flags));
        check("onehot", 32'($onehot0(gnt)), 32'd1);
        if (done) begin
            gi = -1;
            for (int i = 0; i < R; i++) if (gnt[i]) gi = i;
            done_owner.push_back(gi);
            done_cyc.push_back(cyc);
        end
    endtask

    task automatic set_ops(input int idx, input logic [N-1:0] a, input logic [N-1:0] b);
        a_in[idx*N +: N] = a;
        b_in[idx*N +: N] = b;
    endtask

    // Single transaction from IDLE: grant, done, back to IDLE with the request dropped.
    task automatic do_op(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [2:0] flags);
        set_ops(idx, a, b);
        req = '0;
        req[idx] = 1'b1;
        step();
        step();
        flags = {agb, aeb, alb};
        req = '0;
        step();
    endtask

    initial begin
        logic [2:0] f;
        int         exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        model_reset();

        // Reset state and round-robin order under full load
        req = 4'b1111;
        #3;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", 32'({agb, aeb, alb}), 32'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        done_owner.delete();
        done_cyc.delete();
        repeat (16) step();
        check("rr_count_ge5", 32'(done_owner.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < done_owner.size(); i++) begin
            check("rr_order", 32'(done_owner[i]), 32'(exp_order[i]));
            if (i > 0) check("rr_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'd3);
        end

        // Lone requester 2, then ptr=2 makes requester 0 beat requester 2
        req = '0;
        repeat (3) step();
        set_ops(2, 8'h5A, 8'h3C);
        req = 4'b0100;
        step();
        check("t2_gnt", 32'(gnt), 32'h4);
        step();
        check("t2_done", 32'(done), 32'd1);
        check("t2_flags", 32'({agb, aeb, alb}), 32'b100);
        req = '0;
        step();
        set_ops(0, 8'h01, 8'h02);
        req = 4'b0101;
        step();
        check("t2_ptr_next", 32'(gnt), 32'h1);
        step();
        req = '0;
        step();

        // Equal operands, then less-than; flags hold between strobes
        do_op(1, 8'hFF, 8'hFF, f);
        check("t3_eq", 32'(f), 32'b010);
        step();
        step();
        check("t3_hold", 32'({agb, aeb, alb}), 32'b010);
        do_op(3, 8'h00, 8'h01, f);
        check("t3_lt", 32'(f), 32'b001);

        // Operand change after the grant edge must not affect the result
        set_ops(0, 8'h10, 8'h80);
        req = 4'b0001;
        step();
        a_in[0 +: N] = 8'hF0;
        step();
        check("t4_latched", 32'({agb, aeb, alb}), 32'b001);
        req = '0;
        step();

        // Asynchronous reset during CMP: everything clears, no done, requester 0 first after release
        set_ops(2, 8'h77, 8'h11);
        req = 4'b0100;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t5_gnt", 32'(gnt), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_flags", 32'({agb, aeb, alb}), 32'd0);
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t5_first", 32'(gnt), 32'h1);
        step();
        req = '0;
        step();

        // Sign-sensitive operands
        do_op(2, 8'h80, 8'h01, f);
`ifdef COMP_ARB_SIGNED_EN
        check("t6_signed", 32'(f), 32'b001);
`else
        check("t6_unsigned", 32'(f), 32'b100);
`endif

        // Random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            req  = ($urandom_range(0, 3) == 0) ? '0 : R'($urandom_range(0, 15));
            a_in = $urandom;
            b_in = $urandom;
            for (int j = 0; j < R; j++)
                if ($urandom_range(0, 3) == 0) b_in[j*N +: N] = a_in[j*N +: N];
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/comp_arbiter.md
# comp_arbiter

Round-robin scheduler that shares one registered N-bit magnitude comparator among R requesters. Each requester posts an operand pair with a level request. The block grants one requester at a time, latches its operands, evaluates a>b / a==b / a<b, and returns a one-cycle done strobe with the result flags. It sits between the combinational-circuit datapath clients and a single comparator resource, replacing per-client comparator instances.

## Interface
- N, 8, operand width in bits (N ≥ 1)
- R, 4, number of requesters (2 ≤ R ≤ 16)

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  R  per-requester request level; bit i = requester i
- a_in  input  R*N  operand a, requester i at bits [i*N +: N]
- b_in  input  R*N  operand b, requester i at bits [i*N +: N]
- gnt  output  R  one-hot grant; all-zero when idle
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle strobe; result flags valid, owner = gnt
- agb  output  1  registered result a > b
- aeb  output  1  registered result a == b
- alb  output  1  registered result a < b

## Operation
- State machine: IDLE, CMP, RESP.
- IDLE, req ≠ 0:
  - Pick the first set req bit searching upward from ptr+1, modulo R.
  - Set gnt to that one-hot.
  - Latch its a/b slices into internal opa/opb.
  - Go to CMP.
- IDLE, req == 0: stay; gnt=0.
- CMP:
  - Compare opa against opb.
  - Register exactly one of agb/aeb/alb high, the other two low.
  - Go to RESP.
- RESP:
  - done=1 and gnt is held.
  - ptr ← granted index.
  - Go to IDLE unconditionally.
- The requester keeps req high until it sees done with its gnt bit set. It may drop req in the done cycle.
- If req is still high in the next IDLE cycle, it is a new request. It competes at lowest priority because of the updated ptr.
- Operands are sampled only on the IDLE→CMP edge. Changes to a_in/b_in after that edge do not affect the current result.
- A req that drops while granted (before done) does not abort the operation. done still fires for the latched operands.
- Result flags hold their value from one done until the next done. They are all zero after reset until the first done.
- Non-granted req bits are ignored until the arbiter returns to IDLE. Requests are not queued beyond the level itself.

## Timing
- Reset values (async assertion, takes effect immediately):
  - Outputs: gnt=0, busy=0, done=0, agb=aeb=alb=0.
  - Internal: state=IDLE, ptr=R-1, so requester 0 has first priority.
- Reset deasserts synchronously to clk. The first grant is possible at the first rising edge after release.
- Latency: req sampled high in IDLE at edge k. Then:
  - gnt/busy high from k.
  - Flags update at k+1.
  - done high for the cycle following edge k+1.
  - IDLE again at k+2.
- Throughput: one comparison per 3 cycles. Back-to-back grants are possible with no extra idle cycle beyond IDLE itself.
- Reset mid-operation (CMP or RESP): the operation is dropped with no done; all outputs return to reset values.
- Width: comparison is over all N bits with no truncation. With N=1, only {0,1} operands are possible.

## Configuration
- COMP_ARB_SIGNED_EN defined: opa/opb are compared as N-bit two's-complement signed values.
- COMP_ARB_SIGNED_EN undefined (default): unsigned magnitude comparison.
- No port or timing change either way.

## Test plan
- Reset with req=4'b1111, then release: grant order is 0,1,2,3,0 and each done is 3 cycles apart. gnt is never non-one-hot.
- R=4, N=8, requester 2 alone with a=8'h5A, b=8'h3C: gnt=4'b0100 at k, done at k+1 cycle with agb=1, aeb=0, alb=0. ptr then equals 2.
- Requester 1 with a=b=8'hFF, then requester 3 with a=8'h00, b=8'h01: first done gives aeb=1, second gives alb=1. Flags hold between strobes.
- Requester 0 changes a_in from 8'h10 to 8'hF0 during CMP, b=8'h80: result is alb=1 (latched 8'h10), not agb.
- Assert rst_n=0 during CMP: done never pulses; flags, gnt and busy go to 0 immediately. The next grant after release goes to requester 0.
- With COMP_ARB_SIGNED_EN, a=8'h80, b=8'h01: alb=1. Without the macro, the same stimulus gives agb=1.
